fir_mac_sequencer: RTL and testbench
====================================

// Module: fir_mac_sequencer
// PURPOSE
//  Control and datapath stage directly upstream of the shift-add multiplier in the FIR filter.
//  Holds the tap coefficients and the sample delay line, and feeds one coefficient/sample pair
//  per tap to the multiplier over its lm/lq/s/done handshake.
//  Accumulates the products and presents one filter output per accepted input sample.
//  Arithmetic is unsigned throughout, matching the multiplier.
// PARAMETERS
//  N      16  sample and coefficient width; must equal the multiplier's n
//  TAPS    8  number of taps, power of two, 2..64
//  ACC_W  (localparam) 2*N + clog2(TAPS); accumulator width, 35 at defaults
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  rstn        in   1       asynchronous, active-low reset
//  in_valid    in   1       input sample valid
//  in_ready    out  1       sample accepted when in_valid & in_ready
//  in_data     in   N       input sample x[n]
//  coef_we     in   1       coefficient write strobe
//  coef_addr   in   clog2(TAPS)  coefficient index k
//  coef_wdata  in   N       coefficient value c[k]
//  mul_lm      out  1       multiplier multiplicand load
//  mul_lq      out  1       multiplier multiplier-operand load
//  mul_s       out  1       multiplier start, level
//  mul_datam   out  N       coefficient c[k] to the multiplier
//  mul_dataq   out  N       sample x[k] to the multiplier
//  mul_p       in   2N      multiplier product
//  mul_done    in   1       multiplier done, level
//  out_valid   out  1       filter output valid, held until accepted
//  out_ready   in   1       downstream accept
//  out_data    out  2N      y[n] = sum over k of c[k]*x[n-k]
//  out_ovf     out  1       accumulator exceeded 2N bits for this output
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; out_data=0; out_ovf=0; mul_lm, mul_lq and mul_s = 0.
//    Also on reset: coefficient regs = 0, delay line = 0, acc = 0, k = 0.
//  Reset mid-operation aborts the sum. The multiplier shares rstn, so both sides restart clean.
//  FSM states:
//    IDLE: in_ready=1. On accept: shift x[TAPS-1:1] <= x[TAPS-2:0], x[0] <= in_data; acc <= 0; k <= 0 -> LOAD.
//    LOAD: 1 cycle; mul_lm = mul_lq = 1; datam = c[k], dataq = x[k]; mul_s = 0 -> RUN.
//    RUN:  mul_s = 1 until mul_done is sampled 1. On that edge acc <= acc + mul_p -> NEXT.
//    NEXT: 1 cycle; mul_s = 0 so the multiplier returns to its idle state and clears p.
//          If k == TAPS-1 -> OUT; else k <= k+1 -> LOAD.
//    OUT:  out_valid = 1; out_data and out_ovf are stable while out_valid is high.
//          On out_ready -> IDLE, and out_valid drops the next cycle.
//  mul_lm and mul_lq are asserted only in LOAD. mul_s is asserted only in RUN.
//  in_ready = 1 only in IDLE. No new sample is accepted while a sum or an output is pending.
//  x[k]=0 is legal: the multiplier signals done almost immediately with p=0. No special case.
//  coef_we is honoured only while in_ready = 1. In any other state the write is dropped silently.
//  Latency from accept to out_valid: sum over taps of (3 + multiplier run cycles).
//  Acc width is ACC_W, so the accumulator itself never wraps. out_ovf = |acc[ACC_W-1:2N].
// CONFIGURATION
//  FIR_SAT_EN defined:   on overflow, out_data = {2N{1'b1}}; otherwise out_data = acc[2N-1:0].
//  FIR_SAT_EN undefined: out_data = acc[2N-1:0] (wraps). out_ovf behaves the same in both builds.
// STRUCTURE
//  Shared header fir_defs.vh: FIR_N, FIR_TAPS and the FSM state encodings
//    (IDLE, LOAD, RUN, NEXT, OUT as 3-bit localparams).
//  One sub-module, fir_tap_bank: coefficient regs plus delay line.
//    Inputs: write port and shift-in. Outputs: c[k] and x[k] via read muxes.
//  FSM, acc and output register stay in the top module.
// TESTING (bench instantiates the real multiplier on the mul_* ports)
//  1. c[k]=1 for all k; inputs 5,0,0,...(9 samples) -> out_data 5 for 8 outputs, then 0; ovf=0.
//  2. c[k]=k+1; impulse 1 then zeros -> out_data 1,2,3,4,5,6,7,8, then 0.
//  3. c[k]=FFFF; eight samples of FFFF -> 8th output: acc=7_FFF0_0008, out_ovf=1.
//     out_data = FFF00008 without FIR_SAT_EN; FFFFFFFF with it.
//  4. Hold out_ready=0 for 10 cycles in OUT -> out_valid=1 and out_data stable; in_ready=0; mul_s=0.
//  5. coef_we during RUN (c[0]=7) -> ignored. Next output uses the old c[0]. A write in IDLE takes effect.
//  6. Assert rstn=0 mid-RUN -> all outputs at reset values. The next impulse with c=1 yields 1, not the stale sum.

Source files
------------

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared FIR sequencer definitions: default widths and the sequencer FSM state type.
package fir_mac_sequencer_pkg;

  localparam int unsigned FIR_N    = 16;
  localparam int unsigned FIR_TAPS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_NEXT,
    ST_OUT
  } fir_state_e;

endpackage

// File: rtl/fir_tap_bank.sv
// Coefficient registers and sample delay line, with read muxes addressed by the tap index.
module fir_tap_bank
  import fir_mac_sequencer_pkg::*;
#(
  parameter int unsigned N    = FIR_N,
  parameter int unsigned TAPS = FIR_TAPS
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    we,
  input  logic [$clog2(TAPS)-1:0] waddr,
  input  logic [N-1:0]            wdata,
  input  logic                    shift_en,
  input  logic [N-1:0]            shift_data,
  input  logic [$clog2(TAPS)-1:0] rd_addr,
  output logic [N-1:0]            c_rd,
  output logic [N-1:0]            x_rd
);

  logic [N-1:0] coef_q [TAPS];
  logic [N-1:0] coef_d [TAPS];
  logic [N-1:0] x_q    [TAPS];
  logic [N-1:0] x_d    [TAPS];

  always_comb begin
    coef_d = coef_q;
    x_d    = x_q;
    if (we) begin
      coef_d[waddr] = wdata;
    end
    if (shift_en) begin
      for (int unsigned i = TAPS - 1; i > 0; i--) begin
        x_d[i] = x_q[i-1];
      end
      x_d[0] = shift_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_q <= '{default: '0};
      x_q    <= '{default: '0};
    end else begin
      coef_q <= coef_d;
      x_q    <= x_d;
    end
  end

  assign c_rd = coef_q[rd_addr];
  assign x_rd = x_q[rd_addr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: feeds one coefficient/sample pair per tap to a shift-add multiplier and
// accumulates the products. Define FIR_SAT_EN to saturate out_data on accumulator overflow.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int unsigned N    = FIR_N,
  parameter int unsigned TAPS = FIR_TAPS
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [N-1:0]            coef_wdata,
  output logic                    mul_lm,
  output logic                    mul_lq,
  output logic                    mul_s,
  output logic [N-1:0]            mul_datam,
  output logic [N-1:0]            mul_dataq,
  input  logic [2*N-1:0]          mul_p,
  input  logic                    mul_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*N-1:0]          out_data,
  output logic                    out_ovf
);

  localparam int unsigned AW    = $clog2(TAPS);
  localparam int unsigned ACC_W = 2 * N + AW;

  fir_state_e       state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [2*N-1:0]   out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             mul_lm_q, mul_lm_d;
  logic             mul_lq_q, mul_lq_d;
  logic             mul_s_q, mul_s_d;
  logic             accept;
  logic             acc_ovf;
  logic [N-1:0]     c_rd, x_rd;

  // in_ready_q is high exactly in IDLE, so it gates both sample accept and coefficient writes.
  assign accept  = in_valid & in_ready_q;
  assign acc_ovf = |acc_q[ACC_W-1:2*N];

  fir_tap_bank #(
    .N   (N),
    .TAPS(TAPS)
  ) u_tap_bank (
    .clk       (clk),
    .rstn      (rstn),
    .we        (coef_we & in_ready_q),
    .waddr     (coef_addr),
    .wdata     (coef_wdata),
    .shift_en  (accept),
    .shift_data(in_data),
    .rd_addr   (k_q),
    .c_rd      (c_rd),
    .x_rd      (x_rd)
  );

  // Strobes are registered, so each is set on the transition into the state that owns it.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    mul_lm_d    = 1'b0;
    mul_lq_d    = 1'b0;
    mul_s_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d      = '0;
          k_d        = '0;
          in_ready_d = 1'b0;
          mul_lm_d   = 1'b1;
          mul_lq_d   = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mul_s_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        mul_s_d = 1'b1;
        if (mul_done) begin
          acc_d   = acc_q + ACC_W'(mul_p);
          mul_s_d = 1'b0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (k_q == AW'(TAPS - 1)) begin
          out_valid_d = 1'b1;
          out_ovf_d   = acc_ovf;
`ifdef FIR_SAT_EN
          out_data_d  = acc_ovf ? '1 : acc_q[2*N-1:0];
`else
          out_data_d  = acc_q[2*N-1:0];
`endif
          state_d     = ST_OUT;
        end else begin
          k_d      = k_q + 1'b1;
          mul_lm_d = 1'b1;
          mul_lq_d = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      mul_lm_q    <= 1'b0;
      mul_lq_q    <= 1'b0;
      mul_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      mul_lm_q    <= mul_lm_d;
      mul_lq_q    <= mul_lq_d;
      mul_s_q     <= mul_s_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign mul_lm    = mul_lm_q;
  assign mul_lq    = mul_lq_q;
  assign mul_s     = mul_s_q;
  assign mul_datam = c_rd;
  assign mul_dataq = x_rd;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer with a behavioural shift-add multiplier on the mul_* port.
module tb_fir_mac_sequencer;

  localparam int unsigned N    = 16;
  localparam int unsigned TAPS = 8;
  localparam int unsigned AW   = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_data;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [N-1:0]    coef_wdata;
  logic            mul_lm, mul_lq, mul_s;
  logic [N-1:0]    mul_datam, mul_dataq;
  logic [2*N-1:0]  mul_p;
  logic            mul_done;
  logic            out_valid;
  logic            out_ready;
  logic [2*N-1:0]  out_data;
  logic            out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N(N), .TAPS(TAPS)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .mul_lm(mul_lm), .mul_lq(mul_lq), .mul_s(mul_s),
    .mul_datam(mul_datam), .mul_dataq(mul_dataq),
    .mul_p(mul_p), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  // Shift-add multiplier: one multiplier bit per cycle while s is high; done once q is exhausted.
  logic [2*N-1:0] mm, mp;
  logic [N-1:0]   mq;
  logic           md;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm <= '0; mq <= '0; mp <= '0; md <= 1'b0;
    end else begin
      if (mul_lm) mm <= {{N{1'b0}}, mul_datam};
      if (mul_lq) mq <= mul_dataq;
      if (!mul_s) begin
        mp <= '0; md <= 1'b0;
      end else if (!md) begin
        if (mq == '0) md <= 1'b1;
        else begin
          if (mq[0]) mp <= mp + mm;
          mm <= mm << 1;
          mq <= mq >> 1;
        end
      end
    end
  end
  assign mul_p    = mp;
  assign mul_done = md;

  // Reference model: y[n] = sum_k c[k]*x[n-k] in wide arithmetic.
  logic [N-1:0] m_coef [TAPS];
  logic [N-1:0] m_hist [TAPS];

  function automatic logic [63:0] model_sum();
    logic [63:0] s = 64'd0;
    for (int k = 0; k < TAPS; k++) s += 64'(m_coef[k]) * 64'(m_hist[k]);
    return s;
  endfunction

  function automatic logic [31:0] model_data(input logic [63:0] s);
`ifdef FIR_SAT_EN
    return (s[63:32] != 32'd0) ? 32'hFFFF_FFFF : s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  task automatic model_shift(input logic [N-1:0] v);
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = v;
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin m_coef[k] = '0; m_hist[k] = '0; end
  endtask

  task automatic write_coef(input int k, input logic [N-1:0] v);
    coef_we = 1'b1; coef_addr = AW'(k); coef_wdata = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_coef[k] = v;
  endtask

  task automatic start_sample(input logic [N-1:0] v, output bit to);
    int n = 0;
    to = 1'b0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin to = 1'b1; return; end
    in_valid = 1'b1; in_data = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_shift(v);
  endtask

  task automatic wait_out(output bit to);
    int n = 0;
    to = 1'b0;
    while (!out_valid && n < 3000) begin @(posedge clk); #1; n++; end
    if (!out_valid) to = 1'b1;
  endtask

  task automatic wait_run(output bit to);
    int n = 0;
    to = 1'b0;
    while (!mul_s && n < 50) begin @(posedge clk); #1; n++; end
    if (!mul_s) to = 1'b1;
  endtask

  // One full transaction with out_ready high; leaves the DUT back in IDLE.
  task automatic run_sample(input logic [N-1:0] v, output logic [31:0] d, output logic o,
                            output bit to);
    d = '0; o = 1'b0;
    start_sample(v, to);
    if (to) return;
    wait_out(to);
    if (to) return;
    d = out_data; o = out_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b exp 0", out_ovf); end
    checks++; if ({mul_lm, mul_lq, mul_s} !== 3'b000) begin errors++; $display("FAIL reset_mul_ctl: got %b exp 000", {mul_lm, mul_lq, mul_s}); end
  endtask

  task automatic test_unit_coef();
    logic [31:0] d; logic o; bit to; logic [63:0] s;
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'd1);
    for (int i = 0; i < 9; i++) begin
      run_sample((i == 0) ? 16'd5 : 16'd0, d, o, to);
      s = model_sum();
      checks++;
      if (to) begin errors++; $display("FAIL unit_coef_timeout: sample %0d", i); end
      else if (d !== model_data(s) || o !== 1'b0) begin
        errors++; $display("FAIL unit_coef[%0d]: got %h/%b exp %h/0", i, d, o, model_data(s));
      end
    end
  endtask

  task automatic test_impulse();
    logic [31:0] d; logic o; bit to; logic [63:0] s;
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
    for (int i = 0; i < 9; i++) begin
      run_sample((i == 0) ? 16'd1 : 16'd0, d, o, to);
      s = model_sum();
      checks++;
      if (to) begin errors++; $display("FAIL impulse_timeout: sample %0d", i); end
      else if (d !== model_data(s) || o !== 1'b0) begin
        errors++; $display("FAIL impulse[%0d]: got %h/%b exp %h/0", i, d, o, model_data(s));
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic o; bit to; logic [63:0] s;
    logic [31:0] exp8;
`ifdef FIR_SAT_EN
    exp8 = 32'hFFFF_FFFF;
`else
    exp8 = 32'hFFF0_0008;
`endif
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      run_sample(16'hFFFF, d, o, to);
      s = model_sum();
      checks++;
      if (to) begin errors++; $display("FAIL overflow_timeout: sample %0d", i); end
      else if (d !== model_data(s) || o !== (s[63:32] != 32'd0)) begin
        errors++; $display("FAIL overflow[%0d]: got %h/%b exp %h/%b", i, d, o, model_data(s), s[63:32] != 32'd0);
      end
    end
    checks++;
    if (d !== exp8 || o !== 1'b1) begin
      errors++; $display("FAIL overflow_full: got %h/%b exp %h/1", d, o, exp8);
    end
  endtask

  task automatic test_backpressure();
    bit to; logic [31:0] e;
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'($urandom_range(1, 255)));
    out_ready = 1'b0;
    start_sample(16'($urandom_range(1, 1000)), to);
    if (!to) wait_out(to);
    e = model_data(model_sum());
    checks++;
    if (to) begin errors++; $display("FAIL backpressure_timeout: no out_valid"); end
    else begin
      if (out_data !== e) begin errors++; $display("FAIL backpressure_data: got %h exp %h", out_data, e); end
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0 || mul_s !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_hold[%0d]: got v=%b d=%h rdy=%b s=%b exp v=1 d=%h rdy=0 s=0",
                   c, out_valid, out_data, in_ready, mul_s, e);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_release: got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_coef_we_busy();
    logic [31:0] d; logic o; bit to; logic [63:0] s;
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'd1);
    start_sample(16'd3, to);
    if (!to) wait_run(to);
    if (!to) begin
      coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'd7;
      @(posedge clk); #1;
      coef_we = 1'b0;
      wait_out(to);
    end
    s = model_sum();
    checks++;
    if (to) begin errors++; $display("FAIL coef_busy_timeout: no output"); end
    else if (out_data !== model_data(s)) begin
      errors++; $display("FAIL coef_busy_ignored: got %h exp %h", out_data, model_data(s));
    end
    @(posedge clk); #1;
    write_coef(0, 16'd7);
    run_sample(16'd3, d, o, to);
    s = model_sum();
    checks++;
    if (to) begin errors++; $display("FAIL coef_idle_timeout: no output"); end
    else if (d !== model_data(s)) begin
      errors++; $display("FAIL coef_idle_applied: got %h exp %h", d, model_data(s));
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d; logic o; bit to;
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'd1);
    run_sample(16'd9, d, o, to);
    run_sample(16'd4, d, o, to);
    start_sample(16'd6, to);
    if (!to) wait_run(to);
    checks++;
    if (to) begin errors++; $display("FAIL reset_mid_timeout: never reached RUN"); end
    @(posedge clk); #1;
    rstn = 1'b0;
    #2;
    test_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'd1);
    run_sample(16'd1, d, o, to);
    checks++;
    if (to) begin errors++; $display("FAIL reset_mid_after_timeout: no output"); end
    else if (d !== 32'd1 || o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: got %h/%b exp 00000001/0", d, o);
    end
  endtask

  task automatic test_random();
    logic [31:0] d; logic o; bit to; logic [63:0] s; logic [N-1:0] v;
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'($urandom));
    for (int i = 0; i < 12; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      run_sample(v, d, o, to);
      s = model_sum();
      checks++;
      if (to) begin errors++; $display("FAIL random_timeout: sample %0d", i); end
      else if (d !== model_data(s) || o !== (s[63:32] != 32'd0)) begin
        errors++; $display("FAIL random[%0d]: got %h/%b exp %h/%b", i, d, o, model_data(s), s[63:32] != 32'd0);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset();
    test_unit_coef();
    test_impulse();
    test_overflow();
    test_backpressure();
    test_coef_we_busy();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
